instruction_fetch: RTL

//  Upstream neighbour of the control unit in the 16-bit multicycle CPU. Owns the
//  PC and instruction register. Runs the memory read handshake (readM/inputReady)
//  and presents a stable inst word to the decoder until the next fetch completes.

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC / instruction-register owner for the 16-bit multicycle
// CPU. Runs the readM/inputReady memory handshake, holds the fetched word
// stable for the decoder, and applies jump/branch loads from the control path.
//
// Ports:
//   clk, reset_n          clock; synchronous reset, active high (1 = reset)
//   fetch_req             request the next instruction
//   pc_load, pc_target    jump/branch PC load
//   readM, address        memory read strobe and address (= PC)
//   data, inputReady      memory return word and its valid strobe
//   inst, inst_valid, pc  instruction register, its valid flag and its address
//   busy                  fetch in flight
//   num_inst              (only with FETCH_INST_COUNT_EN) completed fetch count
//
// Build option: define FETCH_INST_COUNT_EN to add the num_inst counter.
module instruction_fetch #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 fetch_req,
  input  logic                 pc_load,
  input  logic [WORD_SIZE-1:0] pc_target,
  output logic                 readM,
  output logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 inst_valid,
  output logic [WORD_SIZE-1:0] pc,
`ifdef FETCH_INST_COUNT_EN
  output logic [WORD_SIZE-1:0] num_inst,
`endif
  output logic                 busy
);

  typedef enum logic {IDLE, FETCH} state_t;

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_t               state;
  logic [WORD_SIZE-1:0] pc_q;      // address of the next/current fetch
  logic [WORD_SIZE-1:0] pend_pc;   // jump target seen while a fetch was in flight
  logic                 pend_vld;

  // Memory always sees the live PC; it is only meaningful while readM is high.
  assign address = pc_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      pend_pc    <= '0;
      pend_vld   <= 1'b0;
      inst       <= '0;
      inst_valid <= 1'b0;
      pc         <= RESET_PC;
      readM      <= 1'b0;
      busy       <= 1'b0;
`ifdef FETCH_INST_COUNT_EN
      num_inst   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A load in the same cycle as fetch_req steers this very fetch.
          if (pc_load) pc_q <= pc_target;
          if (fetch_req) begin
            state      <= FETCH;
            readM      <= 1'b1;
            busy       <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (inputReady) begin
            inst       <= data;
            inst_valid <= 1'b1;
            pc         <= pc_q;
            // A load arriving on the capture cycle is the most recent, so it
            // beats any older pending target; PC+1 wraps naturally.
            if (pc_load)       pc_q <= pc_target;
            else if (pend_vld) pc_q <= pend_pc;
            else               pc_q <= pc_q + ONE;
            pend_vld <= 1'b0;
`ifdef FETCH_INST_COUNT_EN
            num_inst <= num_inst + ONE;
`endif
            // fetch_req on the capture cycle chains the next fetch, no bubble.
            if (!fetch_req) begin
              state <= IDLE;
              readM <= 1'b0;
              busy  <= 1'b0;
            end
          end else if (pc_load) begin
            // Address must stay stable mid-fetch, so park the target.
            pend_pc  <= pc_target;
            pend_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
